// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit serializer that drains a request/status FIFO back-to-back.
// All outputs are registered from the next-state decode, so no input reaches an output combinationally.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_uart_tx,
  input  logic       rst_uart_tx,
  input  logic       start_tx,
  input  logic [7:0] fifo_data,
  input  logic       fifo_tx_status,
  output logic       next_frame,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n, busy_n, nf_n, done_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    done_n  = 1'b0;
    case (state)
      // REQ is skipped here: the FIFO pops on the same start_tx pulse.
      IDLE: if (start_tx) state_n = LOAD;
      REQ:  state_n = LOAD;
      LOAD: begin
        if (fifo_tx_status) begin
          sh_n    = fifo_data;
          cnt_n   = '0;
          state_n = START;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = REQ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Output registers take the value belonging to the state being entered.
    tx_n   = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = sh_n[0];
    busy_n = (state_n != IDLE);
    nf_n   = (state_n == REQ);
  end

  always_ff @(posedge clk_uart_tx) begin
    if (rst_uart_tx) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      sh         <= 8'h00;
      tx         <= 1'b1;
      busy       <= 1'b0;
      next_frame <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      tx         <= tx_n;
      busy       <= busy_n;
      next_frame <= nf_n;
      tx_done    <= done_n;
    end
  end
endmodule
